// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter stage.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0080;
   localparam int          PC_INC_DEF   = 4;
   localparam int          RAS_DEPTH_DEF = 4;

   function automatic int ras_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pc_if.sv
// Fetch-side bundle of the PC stage. The PC unit is the master (it issues fetch
// addresses); PC_ALIGN_CHECK_EN adds the misalign_err output.
interface pc_if #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
);
   import pc_pkg::*;
   localparam int CW = ras_cnt_w(RAS_DEPTH);

   logic              fetch_ready;
   logic              exc_req;
   logic              redir_req;
   logic [ADDR_W-1:0] redir_target;
   logic              call_push;
   logic [ADDR_W-1:0] call_ret_addr;
   logic              ret_pop;
   logic [ADDR_W-1:0] ret_fallback;
   logic              halt_req;
   logic [ADDR_W-1:0] PCResult;
   logic              pc_valid;
   logic [CW-1:0]     ras_count;
   logic [ADDR_W-1:0] debug_PCR;
`ifdef PC_ALIGN_CHECK_EN
   logic              misalign_err;
`endif

   modport master (
      input  fetch_ready, exc_req, redir_req, redir_target, call_push,
             call_ret_addr, ret_pop, ret_fallback, halt_req,
`ifdef PC_ALIGN_CHECK_EN
      output misalign_err,
`endif
      output PCResult, pc_valid, ras_count, debug_PCR
   );

   modport slave (
      output fetch_ready, exc_req, redir_req, redir_target, call_push,
             call_ret_addr, ret_pop, ret_fallback, halt_req,
`ifdef PC_ALIGN_CHECK_EN
      input  misalign_err,
`endif
      input  PCResult, pc_valid, ras_count, debug_PCR
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is a no-op, push+pop replaces the top in place.
module pc_ras
   import pc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
)(
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        flush,
   input  logic                        push,
   input  logic                        pop,
   input  logic [ADDR_W-1:0]           push_data,
   output logic [ADDR_W-1:0]           top_data,
   output logic [ras_cnt_w(DEPTH)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = ras_cnt_w(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PW-1:0]     top;
   logic              empty;
   logic              swap;

   assign empty    = (count == '0);
   // A pop on an empty stack does nothing, so push+pop then acts as a plain push.
   assign swap     = push && pop && !empty;
   assign top_data = mem[top];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         top   <= '0;
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (swap) begin
         top   <= top;
      end else if (push) begin
         top <= top + PW'(1);
         if (count != CW'(DEPTH))
            count <= count + CW'(1);
      end else if (pop && !empty) begin
         top   <= top - PW'(1);
         count <= count - CW'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset && !flush && push)
         mem[swap ? top : top + PW'(1)] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: BOOT/RUN/HALT FSM, prioritised next-PC mux, RAS.
// Optional PC_ALIGN_CHECK_EN: misaligned redirect targets trap to EXC_VEC.
module pc_unit
   import pc_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC),
   parameter int                PC_INC    = PC_INC_DEF,
   parameter int                RAS_DEPTH = RAS_DEPTH_DEF
)(
   input  logic Clk,
   input  logic Reset,
   pc_if.master bus
);
   localparam int CW = ras_cnt_w(RAS_DEPTH);

   pc_state_e         state, state_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt, tgt, ras_top;
   logic              tgt_load, ras_push, ras_pop, ras_flush, misaligned;
   logic [CW-1:0]     ras_cnt;

   pc_ras #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
      .Clk       (Clk),
      .Reset     (Reset),
      .flush     (ras_flush),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (bus.call_ret_addr),
      .top_data  (ras_top),
      .count     (ras_cnt)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= BOOT;
         pc_q  <= RESET_VEC;
      end else begin
         state <= state_nxt;
         pc_q  <= pc_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc_q;
      tgt        = '0;
      tgt_load   = 1'b0;
      ras_push   = 1'b0;
      ras_pop    = 1'b0;
      ras_flush  = 1'b0;
      misaligned = 1'b0;
      case (state)
         BOOT: state_nxt = RUN;
         RUN, HALT: begin
            if (bus.exc_req) begin
               pc_nxt    = EXC_VEC;
               state_nxt = RUN;
               ras_flush = 1'b1;
            end else if (bus.redir_req) begin
               tgt       = bus.redir_target;
               tgt_load  = 1'b1;
               state_nxt = RUN;
            end else if (state == RUN) begin
               // Calls still record their return address in the halting cycle.
               ras_push = bus.call_push;
               if (bus.halt_req) begin
                  state_nxt = HALT;
               end else if (bus.ret_pop) begin
                  ras_pop  = 1'b1;
                  tgt      = (ras_cnt != '0) ? ras_top : bus.ret_fallback;
                  tgt_load = 1'b1;
               end else if (bus.fetch_ready) begin
                  pc_nxt = pc_q + ADDR_W'(PC_INC);
               end
            end
         end
         default: state_nxt = BOOT;
      endcase
      if (tgt_load) begin
`ifdef PC_ALIGN_CHECK_EN
         misaligned = (tgt[1:0] != 2'b00);
         pc_nxt     = misaligned ? EXC_VEC : tgt;
`else
         pc_nxt     = tgt;
`endif
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge Clk) begin
      if (Reset) bus.misalign_err <= 1'b0;
      else       bus.misalign_err <= misaligned;
   end
`endif

   assign bus.PCResult  = pc_q;
   assign bus.debug_PCR = pc_q;
   assign bus.pc_valid  = (state == RUN);
   assign bus.ras_count = ras_cnt;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter stage, successor to the basic PC register; sits at the head of the fetch stage and drives the instruction-memory address.
- Adds a fetch valid/ready handshake, stall hold, and prioritised redirect sources: exception, branch/jump, halt.
- Adds a return-address stack (RAS) that predicts the target of subroutine returns.

Parameters:
- ADDR_W, 32, width of the PC and of all address ports.
- RESET_VEC, 32'h0000_0000, PC value loaded on Reset.
- EXC_VEC, 32'h0000_0080, PC value loaded on exception.
- PC_INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two and at least 2.

Ports:
- Clk  in  1  clock; every register updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- fetch_ready  in  1  instruction memory accepts the current PC this cycle.
- exc_req  in  1  take exception; redirect to EXC_VEC.
- redir_req  in  1  branch/jump resolved taken.
- redir_target  in  ADDR_W  target address for redir_req.
- call_push  in  1  a call was fetched; push call_ret_addr onto the RAS.
- call_ret_addr  in  ADDR_W  return address to push.
- ret_pop  in  1  a return was fetched; redirect to the RAS top.
- ret_fallback  in  ADDR_W  return target used when the RAS is empty.
- halt_req  in  1  stop fetching.
- PCResult  out  ADDR_W  current fetch address, registered.
- pc_valid  out  1  PCResult is a valid fetch request.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of occupied RAS entries.
- debug_PCR  out  ADDR_W  combinational copy of PCResult.

Behaviour:
- Clocking: one clock, Clk. Reset is synchronous and active-high. All state changes on the rising edge of Clk.
- Reset values: PCResult=RESET_VEC, pc_valid=0, ras_count=0, state=BOOT.
- State machine: BOOT, RUN, HALT.
  - BOOT: pc_valid=0; moves to RUN after one cycle unconditionally.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0; PCResult held.
- Next-PC priority, highest first, evaluated each cycle outside BOOT:
  1. exc_req: PCResult<=EXC_VEC, state<=RUN, RAS flushed (ras_count<=0). Honoured in HALT.
  2. redir_req: PCResult<=redir_target, state<=RUN. Honoured in HALT.
  3. halt_req (RUN only): state<=HALT, PCResult held.
  4. ret_pop (RUN only): PCResult<=RAS top if ras_count>0, else ret_fallback. ret_pop redirects even when fetch_ready=0.
  5. Accept, pc_valid&&fetch_ready: PCResult<=PCResult+PC_INC, truncated to ADDR_W so 0xFFFF_FFFC wraps to 0.
  6. Otherwise (stall): hold PCResult.
- Redirect latency: a redirect asserted in cycle N appears on PCResult in cycle N+1.
- RAS storage: circular buffer of RAS_DEPTH entries with a top pointer.
  - Push: write at top+1; ras_count increments, saturating at RAS_DEPTH. A push when full overwrites the oldest entry.
  - Pop when ras_count>0: decrements ras_count. Pop when empty: ras_count stays 0.
  - Push and pop in the same cycle: the popped value is used as the target, the pushed value replaces the top, ras_count is unchanged.
  - call_push and ret_pop are ignored when exc_req or redir_req is asserted in the same cycle, and ignored outside RUN.
- Reset in any state, including mid-stall or HALT, overrides everything; the RAS contents become don't-care.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_err (1 bit, reset 0).
  - When a redir_target or RAS/fallback target with addr[1:0]!=0 would be loaded, the unit loads EXC_VEC instead and pulses misalign_err for one cycle.
- When undefined: targets are loaded unchanged and the port is absent.

Decomposition:
- Shared package pc_pkg holds the state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2) and the default vector constants.
- One natural sub-module: pc_ras (circular RAS: push/pop/flush, count, top).
- pc_unit contains the FSM, the priority mux and the PC register.

Test Plan:
- Reset, then fetch_ready=1 held for 5 cycles -> PCResult 0x0,0x0(BOOT),0x4,0x8,0xC; pc_valid 0,1,1,1,1.
- fetch_ready=0 for 3 cycles at PC=0x10 -> PCResult holds 0x10; then fetch_ready=1 -> 0x14.
- redir_req with target 0x200 and exc_req in the same cycle -> next PCResult=0x80, ras_count=0; redir alone -> 0x200.
- Push 0x100,0x104,0x108,0x10C,0x110 with RAS_DEPTH=4 -> ras_count=4; five pops -> targets 0x110,0x10C,0x108,0x104, then ret_fallback; ras_count ends at 0.
- halt_req at PC=0x40 -> pc_valid=0, PC holds for 10 cycles; redir_req to 0x300 -> RUN, PCResult=0x300.
- PC_ALIGN_CHECK_EN defined: redir_target 0x202 -> PCResult=0x80, misalign_err=1 for exactly one cycle. Reset asserted mid-HALT -> PCResult=0x0, BOOT.
